// File: rtl/monolith_perm_ctrl.sv
// ---------------------------------------------------------------------------
// monolith_perm_ctrl
//
// Sequencer for an external Monolith round unit. Accepts one permutation
// state, runs it through ROUND_COUNT round-unit passes, and presents the
// result on a valid/ready output. Each pass issues the working state with a
// one-cycle strobe, then waits for the round unit's result strobe. A bounded
// wait guards against a silent round unit: on expiry the permutation is
// dropped and a sticky error flag is raised.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake, in_state captured on handshake
//   in_state          : permutation input state
//   out_valid/out_ready: output handshake, out_state held until accepted
//   out_state         : permutation result (working register)
//   rc_table          : per-round constants, static while busy
//   rnd_state_in      : working state presented to the round unit
//   rnd_input_valid   : one-cycle issue strobe to the round unit
//   rnd_pre_round     : high while round_idx is 0
//   rnd_constants     : rc_table[round_idx]
//   rnd_state_out     : round unit result
//   rnd_output_valid  : round unit result strobe
//   busy              : controller not idle
//   round_idx         : current pass index
//   timeout_err       : sticky round-unit timeout flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new input state
// ISSUE | strobe working state into the round unit
// WAIT  | waiting for round unit result, timeout counter running
// DONE  | result on out_state, waiting for consumer
// ---------------------------------------------------------------------------
module monolith_perm_ctrl #(
   parameter int WORD_WIDTH  = 31,
   parameter int STATE_SIZE  = 16,
   parameter int ROUND_COUNT = 6,
   parameter int TIMEOUT     = 64
) (
   input  logic                                                  clk,
   input  logic                                                  reset,
   input  logic                                                  in_valid,
   output logic                                                  in_ready,
   input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]                 in_state,
   output logic                                                  out_valid,
   input  logic                                                  out_ready,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]                 out_state,
   input  logic [ROUND_COUNT-1:0][STATE_SIZE-1:0][WORD_WIDTH-1:0] rc_table,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]                 rnd_state_in,
   output logic                                                  rnd_input_valid,
   output logic                                                  rnd_pre_round,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]                 rnd_constants,
   input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]                 rnd_state_out,
   input  logic                                                  rnd_output_valid,
   output logic                                                  busy,
   output logic [3:0]                                            round_idx,
   output logic                                                  timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                                  r_state;
   state_t                                  w_state_nxt;
   logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]   r_work;
   logic [3:0]                              r_round_idx;
   logic [7:0]                              r_wait_cnt;
   logic                                    r_timeout_err;
   logic [3:0]                              w_idx_inc;
   logic                                    w_wait_tc;
   logic                                    w_last_pass;

   assign w_idx_inc   = r_round_idx + 4'd1;
   assign w_last_pass = (w_idx_inc == 4'(ROUND_COUNT));
   // Down-counter loaded in ISSUE with TIMEOUT-1; reaching zero marks the
   // TIMEOUT-th WAIT cycle.
   assign w_wait_tc   = (r_wait_cnt == 8'd0);

   // Constants follow round_idx directly; round_idx only changes on WAIT
   // exit, so they stay put for the whole ISSUE..WAIT window.
   always_comb begin
      rnd_constants = '0;
      for (int r = 0; r < ROUND_COUNT; r++) begin
         if (r_round_idx == 4'(r)) begin
            rnd_constants = rc_table[r];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the terminal-count cycle takes priority.
            if (rnd_output_valid) begin
               w_state_nxt = w_last_pass ? S_DONE : S_ISSUE;
            end else if (w_wait_tc) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_work        <= '0;
         r_round_idx   <= 4'd0;
         r_wait_cnt    <= 8'd0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_work      <= in_state;
                  r_round_idx <= 4'd0;
               end
            end
            S_ISSUE: begin
               r_wait_cnt <= 8'(TIMEOUT - 1);
            end
            S_WAIT: begin
               if (rnd_output_valid) begin
                  r_work      <= rnd_state_out;
                  r_round_idx <= w_idx_inc;
               end else if (w_wait_tc) begin
                  r_timeout_err <= 1'b1;
                  r_work        <= '0;
                  r_round_idx   <= 4'd0;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready        = (r_state == S_IDLE);
   assign rnd_input_valid = (r_state == S_ISSUE);
   assign out_valid       = (r_state == S_DONE);
   assign busy            = (r_state != S_IDLE);
   assign rnd_state_in    = r_work;
   assign out_state       = r_work;
   assign rnd_pre_round   = (r_round_idx == 4'd0);
   assign round_idx       = r_round_idx;
   assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for monolith_perm_ctrl. A round-unit model adds the round constants
// plus one to every word after a programmable latency; the expected result is
// the input plus ROUND_COUNT plus the column sums of rc_table.
// ---------------------------------------------------------------------------
module tb_monolith_perm_ctrl;

   localparam int W  = 31;
   localparam int S  = 16;
   localparam int R  = 6;
   localparam int TO = 64;

   typedef logic [S-1:0][W-1:0]        st_t;
   typedef logic [R-1:0][S-1:0][W-1:0] rc_t;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   st_t        in_state;
   logic       out_valid;
   logic       out_ready;
   st_t        out_state;
   rc_t        rc_table;
   st_t        rnd_state_in;
   logic       rnd_input_valid;
   logic       rnd_pre_round;
   st_t        rnd_constants;
   st_t        rnd_state_out;
   logic       rnd_output_valid;
   logic       busy;
   logic [3:0] round_idx;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   task automatic note_fail(input string tag);
      errors++;
      $error("FAIL %s", tag);
   endtask

   monolith_perm_ctrl #(
      .WORD_WIDTH (W),
      .STATE_SIZE (S),
      .ROUND_COUNT(R),
      .TIMEOUT    (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_state        (in_state),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_state       (out_state),
      .rc_table        (rc_table),
      .rnd_state_in    (rnd_state_in),
      .rnd_input_valid (rnd_input_valid),
      .rnd_pre_round   (rnd_pre_round),
      .rnd_constants   (rnd_constants),
      .rnd_state_out   (rnd_state_out),
      .rnd_output_valid(rnd_output_valid),
      .busy            (busy),
      .round_idx       (round_idx),
      .timeout_err     (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle budget");
      $fatal(1, "watchdog");
   end

   // cyc is the index of the current clock cycle (bumped just after each edge)
   int  cyc = 0;
   int  deliver_cyc = -1;
   int  lat = 5;
   int  silent_pass = 0;
   int  perm_pass = 0;
   int  last_issue_cyc = 0;
   bit  in_pass = 0;
   st_t cap;
   st_t held;
   st_t exp_work;

   function automatic st_t ref_perm(input st_t s, input rc_t rc);
      st_t    o;
      longint t;
      for (int w = 0; w < S; w++) begin
         t = longint'(s[w]) + R;
         for (int r = 0; r < R; r++) t += longint'(rc[r][w]);
         o[w] = W'(t);
      end
      return o;
   endfunction

   function automatic st_t rand_state();
      st_t o;
      for (int w = 0; w < S; w++) o[w] = W'($urandom);
      return o;
   endfunction

   // Round-unit model: result driven for one cycle, lat cycles after issue
   initial begin
      rnd_output_valid = 1'b0;
      rnd_state_out    = '1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == deliver_cyc) begin
            rnd_output_valid = 1'b1;
            rnd_state_out    = cap;
            exp_work         = cap;
         end else begin
            rnd_output_valid = 1'b0;
            rnd_state_out    = '1;
         end
      end
   end

   // Issue monitor: checks issue-side outputs and arms the round-unit model
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            in_pass = 0;
         end else begin
            if (in_valid && in_ready) perm_pass = 0;
            if (rnd_input_valid) begin
               checks++;
               if (perm_pass >= R) note_fail("issue_in_range");
               checks++;
               if (round_idx !== 4'(perm_pass)) note_fail("issue_round_idx");
               checks++;
               if (rnd_pre_round !== (perm_pass == 0)) note_fail("issue_pre_round");
               checks++;
               if (rnd_state_in !== exp_work) note_fail("issue_state_in");
               if (perm_pass < R) begin
                  checks++;
                  if (rnd_constants !== rc_table[perm_pass]) note_fail("issue_constants");
               end
               held = rnd_constants;
               for (int w = 0; w < S; w++) cap[w] = rnd_state_in[w] + rnd_constants[w] + 31'd1;
               in_pass = 1;
               last_issue_cyc = cyc;
               perm_pass++;
               if (perm_pass != silent_pass) deliver_cyc = cyc + lat;
            end else if (in_pass && busy) begin
               checks++;
               if (rnd_constants !== held) note_fail("const_hold");
               if (cyc == deliver_cyc) in_pass = 0;
            end else begin
               in_pass = 0;
            end
         end
      end
   end

   task automatic send_input(input st_t s, output int hs);
      int n;
      @(posedge clk);
      #1;
      in_state = s;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      checks++;
      if (in_ready !== 1'b1) note_fail("hs_ready");
      hs       = cyc;
      exp_work = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_state = rand_state();
   endtask

   task automatic run_perm(input st_t s, input int l, input int hold);
      st_t exp_out;
      int  hs;
      int  n;
      bit  stable;
      lat       = l;
      exp_out   = ref_perm(s, rc_table);
      out_ready = (hold == 0);
      send_input(s, hs);
      n = 0;
      while (!out_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) note_fail("done_seen");
      checks++;
      if ((cyc - hs) != (1 + R * (1 + l))) note_fail("latency");
      checks++;
      if (perm_pass != R) note_fail("issue_count");
      checks++;
      if (out_state !== exp_out) note_fail("out_state");
      checks++;
      if (in_ready !== 1'b0) note_fail("in_ready_in_done");
      if (hold > 0) begin
         stable = 1;
         repeat (hold) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_state !== exp_out || in_ready !== 1'b0) stable = 0;
         end
         checks++;
         if (stable !== 1'b1) note_fail("hold_stable");
         @(posedge clk);
         #1;
         out_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) note_fail("accept_cycle_valid");
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) note_fail("ready_after_accept");
      checks++;
      if (out_valid !== 1'b0) note_fail("valid_drop");
      out_ready = 1'b1;
   endtask

   initial begin
      st_t s;
      int  hs;
      int  n;
      bit  ok;
      bit  seen_valid;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_state  = '0;
      rc_table  = '0;
      exp_work  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) note_fail("rst_in_ready");
      checks++;
      if (busy !== 1'b0) note_fail("rst_busy");
      checks++;
      if (out_valid !== 1'b0) note_fail("rst_out_valid");
      checks++;
      if (timeout_err !== 1'b0) note_fail("rst_timeout_err");
      checks++;
      if (round_idx !== 4'd0) note_fail("rst_round_idx");
      checks++;
      if (rnd_input_valid !== 1'b0) note_fail("rst_rnd_input_valid");
      checks++;
      if (rnd_state_in !== st_t'(0)) note_fail("rst_rnd_state_in");
      checks++;
      if (out_state !== st_t'(0)) note_fail("rst_out_state");

      // all words 0x10, zero constants, L=5 -> all words 0x16 at cycle 37
      for (int w = 0; w < S; w++) s[w] = 31'h10;
      run_perm(s, 5, 0);
      for (int w = 0; w < S; w++) begin
         checks++;
         if (out_state[w] !== 31'h16) note_fail("word_0x16");
      end

      // rc_table[r] = r in every word, consumer stalls 10 cycles
      for (int r = 0; r < R; r++)
         for (int w = 0; w < S; w++) rc_table[r][w] = W'(r);
      run_perm(rand_state(), 3, 10);

      // latency equal to TIMEOUT still succeeds
      run_perm(rand_state(), TO, 0);
      checks++;
      if (timeout_err !== 1'b0) note_fail("no_timeout_at_limit");

      // round unit silent on pass 2
      silent_pass = 2;
      lat = 7;
      send_input(rand_state(), hs);
      n = 0;
      seen_valid = 0;
      while (!timeout_err && n < 500) begin
         @(negedge clk);
         n++;
         if (out_valid) seen_valid = 1;
      end
      checks++;
      if (timeout_err !== 1'b1) note_fail("timeout_set");
      checks++;
      if ((cyc - last_issue_cyc) != (TO + 1)) note_fail("timeout_cycle");
      checks++;
      if (busy !== 1'b0) note_fail("timeout_idle");
      checks++;
      if (in_ready !== 1'b1) note_fail("timeout_in_ready");
      checks++;
      if (seen_valid !== 1'b0) note_fail("timeout_no_out_valid");
      silent_pass = 0;
      run_perm(rand_state(), 4, 0);
      checks++;
      if (timeout_err !== 1'b1) note_fail("timeout_sticky");

      // reset during pass 3 WAIT, late round-unit strobe must be ignored
      lat = 10;
      send_input(rand_state(), hs);
      n = 0;
      while (perm_pass < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (perm_pass != 3) note_fail("reached_pass3");
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) note_fail("mid_rst_busy");
      checks++;
      if (round_idx !== 4'd0) note_fail("mid_rst_round_idx");
      checks++;
      if (out_valid !== 1'b0) note_fail("mid_rst_out_valid");
      checks++;
      if (timeout_err !== 1'b0) note_fail("mid_rst_timeout_err");
      checks++;
      if (in_ready !== 1'b1) note_fail("mid_rst_in_ready");
      checks++;
      if (rnd_state_in !== st_t'(0)) note_fail("mid_rst_state_in");
      ok = 1;
      repeat (15) begin
         @(negedge clk);
         if (busy !== 1'b0 || rnd_input_valid !== 1'b0 || out_valid !== 1'b0) ok = 0;
      end
      checks++;
      if (ok !== 1'b1) note_fail("stray_ignored");
      checks++;
      if (out_state !== st_t'(0)) note_fail("stray_state_clean");

      // randomized permutations
      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < R; r++) rc_table[r] = rand_state();
         run_perm(rand_state(), int'($urandom_range(1, 12)), int'($urandom_range(0, 4)));
      end
      checks++;
      if (timeout_err !== 1'b0) note_fail("final_no_timeout");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
